// File: rtl/melody_sequencer_if.sv
// Control/status bundle between the melody sequencer and its host.
// TEMPO exists only when MELODY_TEMPO_EN is defined.
interface melody_sequencer_if #(
    parameter int SONG_LEN = 32
);
    localparam int IDX_W = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;

    // PLAY and STOP are one-cycle request pulses with no ready/ack; a PLAY
    // seen while BUSY is dropped, and STOP wins when both arrive together.
    logic             PLAY;
    logic             STOP;
    logic             LOOP;
`ifdef MELODY_TEMPO_EN
    logic [1:0]       TEMPO;
`endif
    logic [7:0]       NOTE_SW;
    logic             BUSY;
    logic [IDX_W-1:0] STEP_IDX;
    logic             DONE;
    logic [1:0]       STATE_DBG;

`ifdef MELODY_TEMPO_EN
    modport master (input PLAY, STOP, LOOP, TEMPO,
                    output NOTE_SW, BUSY, STEP_IDX, DONE, STATE_DBG);
    modport slave  (output PLAY, STOP, LOOP, TEMPO,
                    input NOTE_SW, BUSY, STEP_IDX, DONE, STATE_DBG);
`else
    modport master (input PLAY, STOP, LOOP,
                    output NOTE_SW, BUSY, STEP_IDX, DONE, STATE_DBG);
    modport slave  (output PLAY, STOP, LOOP,
                    input NOTE_SW, BUSY, STEP_IDX, DONE, STATE_DBG);
`endif
endinterface

// File: rtl/melody_sequencer.sv
// Plays a fixed ROM melody as a one-hot note-select vector for the tone stage.
// Define MELODY_TEMPO_EN to add the run-time TEMPO divisor select.
module melody_sequencer #(
    parameter int CLK_HZ    = 100000000,
    parameter int TICK_HZ   = 16,
    parameter int SONG_LEN  = 32,
    parameter int GAP_TICKS = 1
) (
    input  logic CLK,
    input  logic RESET,
    melody_sequencer_if.master bus
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int IDX_W = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam int CNT_W = $clog2(2 * DIV);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);
    localparam logic [7:0]       GAP      = 8'(GAP_TICKS);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_PLAYING = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       rem_q;
    logic [CNT_W-1:0] tick_q;
    logic [3:0]       code_q;
    logic [7:0]       note_sw_q;
    logic             busy_q;
    logic             done_q;

    // Entries 0..7 climb C4..C5 for four ticks each; everything else ends the song.
    function automatic logic [11:0] rom_word(input logic [IDX_W-1:0] a);
        logic [3:0] code;
        code     = 4'(a) + 4'd1;
        rom_word = 12'h000;
        if (32'(a) < 32'd8) rom_word = {code, 8'd4};
    endfunction

    function automatic logic [7:0] decode(input logic [3:0] c);
        decode = 8'h00;
        if (c >= 4'd1 && c <= 4'd8) decode = 8'h80 >> (c - 4'd1);
    endfunction

    logic [11:0]      entry;
    logic [7:0]       rem_dec;
    logic [CNT_W-1:0] div_last;

    assign entry   = rom_word(idx_q);
    assign rem_dec = rem_q - 8'd1;

`ifdef MELODY_TEMPO_EN
    logic [CNT_W-1:0] div_last_q;
    logic [CNT_W-1:0] tempo_last;

    always_comb begin
        tempo_last = DIV_LAST;
        case (bus.TEMPO)
            2'b01:   tempo_last = CNT_W'(DIV / 2 - 1);
            2'b10:   tempo_last = CNT_W'(2 * DIV - 1);
            default: tempo_last = DIV_LAST;
        endcase
    end
    assign div_last = div_last_q;
`else
    assign div_last = DIV_LAST;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            rem_q     <= 8'd0;
            tick_q    <= '0;
            code_q    <= 4'd0;
            note_sw_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MELODY_TEMPO_EN
            div_last_q <= DIV_LAST;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE && bus.STOP) begin
                state_q   <= S_IDLE;
                idx_q     <= '0;
                note_sw_q <= 8'h00;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.PLAY && !bus.STOP) begin
                            state_q <= S_LOAD;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (entry[7:0] == 8'd0) begin
                            state_q   <= S_FINISH;
                            note_sw_q <= 8'h00;
                            done_q    <= 1'b1;
                        end else begin
                            state_q   <= S_PLAYING;
                            rem_q     <= entry[7:0];
                            tick_q    <= '0;
                            code_q    <= entry[11:8];
                            note_sw_q <= (entry[7:0] > GAP) ? decode(entry[11:8]) : 8'h00;
`ifdef MELODY_TEMPO_EN
                            div_last_q <= tempo_last;
`endif
                        end
                    end
                    S_PLAYING: begin
                        if (tick_q == div_last) begin
                            tick_q    <= '0;
                            rem_q     <= rem_dec;
                            note_sw_q <= (rem_dec > GAP) ? decode(code_q) : 8'h00;
                            if (rem_dec == 8'd0) begin
                                if (idx_q == LAST_IDX) begin
                                    state_q <= S_FINISH;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= S_LOAD;
                                    idx_q   <= idx_q + 1'b1;
                                end
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    S_FINISH: begin
                        if (bus.LOOP) begin
                            state_q <= S_LOAD;
                            idx_q   <= '0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.NOTE_SW   = note_sw_q;
    assign bus.BUSY      = busy_q;
    assign bus.STEP_IDX  = idx_q;
    assign bus.DONE      = done_q;
    assign bus.STATE_DBG = state_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with DIV=4, GAP_TICKS=1, SONG_LEN=32.
// Edge r=1 is the edge that samples PLAY (LOAD follows); expected values come from the song timing.
module tb_melody_sequencer;
    logic CLK;
    logic RESET;
    int   total;
    int   bad;

    melody_sequencer_if #(.SONG_LEN(32)) bus ();

    melody_sequencer #(
        .CLK_HZ(16), .TICK_HZ(4), .SONG_LEN(32), .GAP_TICKS(1)
    ) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Entry j sounds from edge 2+17j for 12 edges, then 5 silent edges.
    function automatic logic [7:0] exp_note(input int r);
        int j;
        int off;
        logic [7:0] top;
        top = 8'h80;
        if (r < 2) return 8'h00;
        j   = (r - 2) / 17;
        off = (r - 2) % 17;
        if (j >= 8) return 8'h00;
        return (off < 12) ? (top >> j) : 8'h00;
    endfunction

    function automatic int exp_idx(input int r);
        int j;
        if (r < 1) return 0;
        j = (r - 1) / 17;
        return (j > 8) ? 8 : j;
    endfunction

    task automatic cycle_checks(input int r_from, input int r_to, input bit loop_mode);
        int rr;
        for (int r = r_from; r <= r_to; r++) begin
            next_edge();
            bus.PLAY = 1'b0;
            bus.STOP = 1'b0;
            rr = r;
            if (loop_mode) while (rr > 138) rr -= 138;
            check_val($sformatf("note@%0d", r), 32'(bus.NOTE_SW), 32'(exp_note(rr)));
            check_val($sformatf("idx@%0d", r), 32'(bus.STEP_IDX), 32'(exp_idx(rr)));
            check_val($sformatf("done@%0d", r), 32'(bus.DONE), (rr == 138) ? 32'd1 : 32'd0);
            check_val($sformatf("busy@%0d", r), 32'(bus.BUSY),
                      (loop_mode || r <= 138) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        #1;
        check_val("async_note", 32'(bus.NOTE_SW), 32'd0);
        check_val("async_busy", 32'(bus.BUSY), 32'd0);
        check_val("async_idx", 32'(bus.STEP_IDX), 32'd0);
        check_val("async_done", 32'(bus.DONE), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

`ifdef MELODY_TEMPO_EN
    task automatic tempo_run(input logic [1:0] t, input int exp_cycles);
        int cnt;
        cnt = 0;
        bus.TEMPO = t;
        bus.PLAY  = 1'b1;
        for (int k = 0; k < 60; k++) begin
            next_edge();
            bus.PLAY = 1'b0;
            if (bus.NOTE_SW == 8'h80) cnt++;
        end
        check_val($sformatf("tempo%0d_len", t), 32'(cnt), 32'(exp_cycles));
        apply_reset();
        bus.TEMPO = 2'b00;
    endtask
`endif

    initial begin
        total    = 0;
        bad      = 0;
        RESET    = 1'b1;
        bus.PLAY = 1'b0;
        bus.STOP = 1'b0;
        bus.LOOP = 1'b0;
`ifdef MELODY_TEMPO_EN
        bus.TEMPO = 2'b00;
`endif
        @(negedge CLK);
        @(negedge CLK);
        check_val("rst_note", 32'(bus.NOTE_SW), 32'd0);
        check_val("rst_busy", 32'(bus.BUSY), 32'd0);
        check_val("rst_idx", 32'(bus.STEP_IDX), 32'd0);
        check_val("rst_done", 32'(bus.DONE), 32'd0);
        check_val("rst_state", 32'(bus.STATE_DBG), 32'd0);
        RESET = 1'b0;

        // Whole song without looping, including the single-note timing.
        bus.PLAY = 1'b1;
        cycle_checks(1, 141, 1'b0);

        // Looping repeats the song with no further input.
        apply_reset();
        bus.LOOP = 1'b1;
        bus.PLAY = 1'b1;
        cycle_checks(1, 160, 1'b1);

        // STOP while entry 2 sounds, then restart.
        apply_reset();
        bus.LOOP = 1'b0;
        bus.PLAY = 1'b1;
        cycle_checks(1, 40, 1'b0);
        check_val("pre_stop_note", 32'(bus.NOTE_SW), 32'h20);
        bus.STOP = 1'b1;
        next_edge();
        bus.STOP = 1'b0;
        check_val("stop_note", 32'(bus.NOTE_SW), 32'd0);
        check_val("stop_busy", 32'(bus.BUSY), 32'd0);
        check_val("stop_idx", 32'(bus.STEP_IDX), 32'd0);
        check_val("stop_done", 32'(bus.DONE), 32'd0);
        for (int k = 0; k < 20; k++) begin
            next_edge();
            check_val("after_stop_done", 32'(bus.DONE), 32'd0);
            check_val("after_stop_busy", 32'(bus.BUSY), 32'd0);
        end
        bus.PLAY = 1'b1;
        cycle_checks(1, 25, 1'b0);

        // Async reset mid-note inside entry 1.
        apply_reset();

        // PLAY and STOP together in IDLE.
        bus.PLAY = 1'b1;
        bus.STOP = 1'b1;
        next_edge();
        bus.PLAY = 1'b0;
        bus.STOP = 1'b0;
        check_val("prio_busy", 32'(bus.BUSY), 32'd0);
        check_val("prio_state", 32'(bus.STATE_DBG), 32'd0);
        next_edge();
        check_val("prio_busy2", 32'(bus.BUSY), 32'd0);

        // PLAY while busy is ignored.
        bus.PLAY = 1'b1;
        cycle_checks(1, 20, 1'b0);
        bus.PLAY = 1'b1;
        cycle_checks(21, 40, 1'b0);
        apply_reset();

`ifdef MELODY_TEMPO_EN
        tempo_run(2'b01, 6);
        tempo_run(2'b10, 24);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream stage of the piano tone-select stage.
- Plays a fixed melody from an internal ROM. Produces the 8-bit one-hot note-select vector that the tone-select stage takes in place of the physical switches: bit7 = C4, bit6 = D, bit5 = E, bit4 = F, bit3 = G, bit2 = A, bit1 = B, bit0 = C5, all-zero = silence.
- Tempo comes from an internal tick divider. Play and stop are single-cycle pulses, and looping is optional at run time.

Parameters:
- CLK_HZ, 100000000: system clock frequency.
- TICK_HZ, 16: duration tick rate. DIV = CLK_HZ/TICK_HZ clock cycles per tick, integer, DIV >= 2.
- SONG_LEN, 32: ROM depth in entries.
- GAP_TICKS, 1: silent ticks at the end of every note, for articulation.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- PLAY  in  1  single-cycle start pulse.
- STOP  in  1  single-cycle abort pulse.
- LOOP  in  1  level; 1 = restart the song at its end.
- NOTE_SW  out  8  registered one-hot note select, or 0 for silence.
- BUSY  out  1  registered; 1 while in any state other than IDLE.
- STEP_IDX  out  clog2(SONG_LEN)  registered index of the current ROM entry.
- DONE  out  1  registered single-cycle pulse at normal song end.

Behaviour:
- Reset: CLK is the clock; RESET is asynchronous and active-high. On reset, state = IDLE, NOTE_SW = 0, BUSY = 0, DONE = 0, STEP_IDX = 0, tick counter = 0, remaining counter = 0. Reset mid-song aborts immediately with no DONE.
- ROM entry format, 12 bits:
  - [11:8] note code: 0 = rest, 1..8 = C4..C5, 9..15 = rest.
  - [7:0] duration in ticks; 0 = end-of-song marker.
- Note decode: code n in 1..8 gives NOTE_SW = 8'h80 >> (n-1).
- ROM contents: entries 0..7 = codes 1..8, duration 4 each; entry 8 = terminator; remaining entries = terminator.
- States:
  - IDLE: outputs 0. PLAY with no STOP moves to LOAD with idx = 0.
  - LOAD (1 cycle): read ROM[idx]. Duration 0 moves to FINISH. Otherwise set rem = duration, clear the tick counter, and move to PLAYING.
  - PLAYING: tick counter counts 0..DIV-1; a tick occurs on the cycle it wraps, and rem decrements on each tick.
    - NOTE_SW = decode while rem > GAP_TICKS, and 0 otherwise. If duration <= GAP_TICKS the entry is silent for its whole length.
    - When a tick takes rem to 0: if idx == SONG_LEN-1, move to FINISH; else idx+1 and move to LOAD.
  - FINISH (1 cycle): DONE = 1 and NOTE_SW = 0. Then LOOP = 1 gives idx = 0 and LOAD; LOOP = 0 gives IDLE.
- Timing:
  - PLAY sampled at edge k: LOAD during cycle k+1, and NOTE_SW is valid from edge k+2.
  - Each note entry lasts 1 + duration*DIV cycles: sound for (duration - GAP_TICKS)*DIV cycles, then silence for GAP_TICKS*DIV + 1 cycles, which includes the next LOAD.
- STOP in any non-IDLE state: next edge gives IDLE, NOTE_SW = 0, BUSY = 0, STEP_IDX = 0, no DONE.
- Priority: STOP beats PLAY in the same cycle. PLAY while BUSY is ignored.
- NOTE_SW is never multi-hot. STEP_IDX wraps only via FINISH/LOOP, never by overflow.

Optional Feature:
- Macro MELODY_TEMPO_EN.
- Defined: adds input TEMPO, 2 bits. Effective divisor: 00 = DIV, 01 = DIV/2, 10 = DIV*2, 11 = DIV. TEMPO is sampled in LOAD and held for the whole entry.
- Undefined: TEMPO port absent; divisor fixed at DIV.

Test Plan (CLK_HZ=16, TICK_HZ=4, so DIV=4; GAP_TICKS=1; SONG_LEN=32):
- Single note: release reset, pulse PLAY at edge 0.
  - NOTE_SW = 0x80 for edges 2..13 (12 cycles).
  - 0 for edges 14..18; LOAD occurs in cycle 18.
  - 0x40 from edge 19; STEP_IDX = 1 at edge 18.
- Full song, LOOP = 0:
  - NOTE_SW steps 0x80, 0x40, 0x20, 0x10, 0x08, 0x04, 0x02, 0x01, each 12 cycles on, separated by 5 cycles of 0.
  - DONE pulses exactly once, 2 cycles after the final gap ends.
  - BUSY = 0 the cycle after DONE.
- LOOP = 1: after DONE, NOTE_SW = 0x80 two cycles later and STEP_IDX = 0. The sequence repeats with no further input.
- STOP during entry 2 (NOTE_SW = 0x20): next edge gives NOTE_SW = 0, BUSY = 0, STEP_IDX = 0, DONE never asserted. A following PLAY restarts at 0x80.
- Async RESET mid-note: NOTE_SW, BUSY and STEP_IDX go to 0 without waiting for a CLK edge. PLAY and STOP pulsed in the same cycle in IDLE leave the block in IDLE. PLAY pulsed while BUSY leaves STEP_IDX unchanged.
- With MELODY_TEMPO_EN and TEMPO = 01: first note sounds 6 cycles; TEMPO = 10 gives 24 cycles.
